// File: rtl/washer_pkg.sv
// Shared types and constants for the washing machine controller: phase
// enumeration, phase durations in prescaler ticks, and the 7-segment digit table.
package washer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_WASH   = 3'd2,
        S_RINSE  = 3'd3,
        S_RINSE2 = 3'd4,
        S_SPIN   = 3'd5,
        S_SPIN2  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [3:0] FILL_S  = 4'd2;
    localparam logic [3:0] FILL_M  = 4'd3;
    localparam logic [3:0] FILL_L  = 4'd4;
    localparam logic [3:0] WASH_C  = 4'd3;
    localparam logic [3:0] WASH_W  = 4'd4;
    localparam logic [3:0] WASH_H  = 4'd5;
    localparam logic [3:0] RINSE_T = 4'd3;
    localparam logic [3:0] SPIN_T  = 4'd2;

    // Size code {sw1,sw0}: 00 small, 01 medium, 10/11 large.
    function automatic logic [3:0] fill_ticks(input logic [1:0] size);
        case (size)
            2'b00:   fill_ticks = FILL_S;
            2'b01:   fill_ticks = FILL_M;
            default: fill_ticks = FILL_L;
        endcase
    endfunction

    // Temperature code {sw3,sw2}: 01 cold, 10 hot, 00/11 warm.
    function automatic logic [3:0] wash_ticks(input logic [1:0] temp);
        case (temp)
            2'b01:   wash_ticks = WASH_C;
            2'b10:   wash_ticks = WASH_H;
            default: wash_ticks = WASH_W;
        endcase
    endfunction

    // Active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'h3F;
            4'd1:    seg_digit = 7'h06;
            4'd2:    seg_digit = 7'h5B;
            4'd3:    seg_digit = 7'h4F;
            4'd4:    seg_digit = 7'h66;
            4'd5:    seg_digit = 7'h6D;
            4'd6:    seg_digit = 7'h7D;
            4'd7:    seg_digit = 7'h07;
            4'd8:    seg_digit = 7'h7F;
            4'd9:    seg_digit = 7'h6F;
            default: seg_digit = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/washer_tick_gen.sv
// Phase time-base prescaler: counts 0..COUNT while enabled and pulses tick
// on the terminal count; clr forces the count back to zero.
module washer_tick_gen #(
    parameter int COUNT_WIDTH = 27,
    parameter int COUNT       = 99_999_999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [COUNT_WIDTH-1:0] TERM = COUNT_WIDTH'(COUNT);

    logic [COUNT_WIDTH-1:0] count_reg;

    assign tick = en & (count_reg == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= (count_reg == TERM) ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/washer_top.sv
// Washing machine controller: timed FSM fill/wash/rinse(/rinse2)/spin(/spin2)/done.
// Define LID_PAUSE_EN to let an open lid pause a running cycle.
module washer_top #(
    parameter int COUNT_WIDTH = 27,
    parameter int COUNT       = 99_999_999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw0,
    input  logic       sw1,
    input  logic       sw2,
    input  logic       sw3,
    input  logic       sw4,
    input  logic       sw5,
    input  logic       sw6,
    input  logic       start_btn,
    output logic [5:0] led,
    output logic [7:0] sevenseg,
    output logic       rinse2,
    output logic       spin2
);

    import washer_pkg::*;

    state_t     state_reg, state_next;
    logic [3:0] timer_reg, timer_next;
    logic [1:0] size_reg, size_next;
    logic [1:0] temp_reg, temp_next;
    logic       rinse2_en_reg, rinse2_en_next;
    logic       spin2_en_reg, spin2_en_next;
    logic       start_q;
    logic       start_edge, start_ok, active, paused, tick;

    assign start_edge = start_btn & ~start_q;
    assign active     = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign start_ok   = start_edge & ~sw6 & ~active;

`ifdef LID_PAUSE_EN
    assign paused = active & sw6;
`else
    assign paused = 1'b0;
`endif

    washer_tick_gen #(
        .COUNT_WIDTH(COUNT_WIDTH),
        .COUNT      (COUNT)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (active & ~paused),
        .clr  (start_ok | ~active),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            size_reg      <= '0;
            temp_reg      <= '0;
            rinse2_en_reg <= 1'b0;
            spin2_en_reg  <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            size_reg      <= size_next;
            temp_reg      <= temp_next;
            rinse2_en_reg <= rinse2_en_next;
            spin2_en_reg  <= spin2_en_next;
            start_q       <= start_btn;
        end
    end

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        size_next      = size_reg;
        temp_next      = temp_reg;
        rinse2_en_next = rinse2_en_reg;
        spin2_en_next  = spin2_en_reg;

        if (!active) begin
            if (start_ok) begin
                size_next      = {sw1, sw0};
                temp_next      = {sw3, sw2};
                rinse2_en_next = sw4;
                spin2_en_next  = sw5;
                state_next     = S_FILL;
                timer_next     = fill_ticks({sw1, sw0});
            end
        end else if (tick) begin
            if (timer_reg == 4'd1) begin
                // Last tick of the phase: advance and load the next phase length.
                case (state_reg)
                    S_FILL: begin
                        state_next = S_WASH;
                        timer_next = wash_ticks(temp_reg);
                    end
                    S_WASH: begin
                        state_next = S_RINSE;
                        timer_next = RINSE_T;
                    end
                    S_RINSE: begin
                        state_next = rinse2_en_reg ? S_RINSE2 : S_SPIN;
                        timer_next = rinse2_en_reg ? RINSE_T : SPIN_T;
                    end
                    S_RINSE2: begin
                        state_next = S_SPIN;
                        timer_next = SPIN_T;
                    end
                    S_SPIN: begin
                        state_next = spin2_en_reg ? S_SPIN2 : S_DONE;
                        timer_next = spin2_en_reg ? SPIN_T : 4'd0;
                    end
                    default: begin
                        state_next = S_DONE;
                        timer_next = 4'd0;
                    end
                endcase
            end else begin
                timer_next = timer_reg - 4'd1;
            end
        end
    end

    always_comb begin
        led      = '0;
        sevenseg = '0;
        rinse2   = 1'b0;
        spin2    = 1'b0;
        case (state_reg)
            S_FILL:   led[0] = 1'b1;
            S_WASH:   led[1] = 1'b1;
            S_RINSE:  led[2] = 1'b1;
            S_RINSE2: begin
                led[2] = 1'b1;
                rinse2 = 1'b1;
            end
            S_SPIN:   led[3] = 1'b1;
            S_SPIN2:  begin
                led[3] = 1'b1;
                spin2  = 1'b1;
            end
            S_DONE:   led[4] = 1'b1;
            default:  led = '0;
        endcase
        if (active) begin
            led[5]   = paused;
            sevenseg = {paused, seg_digit(timer_reg)};
        end else if (state_reg == S_DONE) begin
            sevenseg = {1'b0, seg_digit(4'd0)};
        end
    end

endmodule

// File: tb/tb_washer_top.sv
// Self-checking bench for washer_top with a 10-cycle tick; expected outputs come
// from a phase schedule model (elapsed unpaused cycles vs. cumulative durations).
`timescale 1ns/1ps
module tb_washer_top;

`ifdef LID_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif
    localparam int TPT = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw0 = 0, sw1 = 0, sw2 = 0, sw3 = 0, sw4 = 0, sw5 = 0, sw6 = 0;
    logic       start_btn = 1'b0;
    logic [5:0] led;
    logic [7:0] sevenseg;
    logic       rinse2, spin2;

    int checks = 0;
    int failures = 0;

    washer_top #(.COUNT_WIDTH(8), .COUNT(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .sw0(sw0), .sw1(sw1), .sw2(sw2), .sw3(sw3), .sw4(sw4), .sw5(sw5), .sw6(sw6),
        .start_btn(start_btn), .led(led), .sevenseg(sevenseg), .rinse2(rinse2), .spin2(spin2)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'h3F; 1: seg_of = 7'h06; 2: seg_of = 7'h5B; 3: seg_of = 7'h4F;
            4: seg_of = 7'h66; 5: seg_of = 7'h6D; 6: seg_of = 7'h7D; 7: seg_of = 7'h07;
            8: seg_of = 7'h7F; 9: seg_of = 7'h6F; default: seg_of = 7'h00;
        endcase
    endfunction

    task automatic check_idle(input string name);
        checks++;
        if (led !== 6'd0 || sevenseg !== 8'd0 || rinse2 !== 1'b0 || spin2 !== 1'b0) begin
            failures++;
            $display("FAIL %s idle outputs got led=%b seg=%h r2=%b s2=%b exp all zero",
                     name, led, sevenseg, rinse2, spin2);
        end
    endtask

    // One complete wash cycle started from IDLE/DONE, checked every clock.
    task automatic run_cycle(input logic [1:0] size, input logic [1:0] temp, input bit r2, input bit s2,
                             input int pause_at, input int pause_len, input int hold,
                             input bit abort_spin, input string name);
        int dur[6]; int ledb[6]; int kind[6];
        int n, elapsed, k, idx, rem, acc, pstart, done_cnt, f0;
        bit act, pz;
        logic [5:0] exp_led;
        logic [7:0] exp_seg;
        logic exp_r2, exp_s2;

        n = 0;
        dur[n] = (size == 2'b00) ? 2 : (size == 2'b01) ? 3 : 4; ledb[n] = 0; kind[n] = 0; n++;
        dur[n] = (temp == 2'b01) ? 3 : (temp == 2'b10) ? 5 : 4; ledb[n] = 1; kind[n] = 0; n++;
        dur[n] = 3; ledb[n] = 2; kind[n] = 0; n++;
        if (r2) begin dur[n] = 3; ledb[n] = 2; kind[n] = 1; n++; end
        dur[n] = 2; ledb[n] = 3; kind[n] = 0; n++;
        if (s2) begin dur[n] = 2; ledb[n] = 3; kind[n] = 2; n++; end

        f0 = failures;
        {sw1, sw0} = size; {sw3, sw2} = temp; sw4 = r2; sw5 = s2; sw6 = 1'b0;
        start_btn = 1'b1;
        @(posedge clk); #1;
        elapsed = 0; k = 0; done_cnt = 0;
        while (1) begin
            if (k > 3000) begin
                checks++; failures++;
                $display("FAIL %s timeout waiting for DONE at cycle %0d", name, k);
                break;
            end
            start_btn = (k < hold - 1);
            {sw5, sw4, sw3, sw2, sw1, sw0} = 6'($urandom);
            sw6 = (k >= pause_at) && (k < pause_at + pause_len);
            #1;
            idx = -1; acc = 0; rem = 0; pstart = 0;
            for (int i = 0; i < n; i++) begin
                if (idx < 0) begin
                    if (elapsed < acc + dur[i] * TPT) begin
                        idx = i; pstart = acc;
                        rem = dur[i] - (elapsed - acc) / TPT;
                    end else begin
                        acc += dur[i] * TPT;
                    end
                end
            end
            act = (idx >= 0);
            pz = PAUSE_EN && act && sw6;
            exp_led = act ? (6'd1 << ledb[idx]) : 6'b010000;
            exp_led[5] = pz;
            exp_seg = {pz, seg_of(act ? rem : 0)};
            exp_r2 = act && (kind[idx] == 1);
            exp_s2 = act && (kind[idx] == 2);

            checks++;
            if (led !== exp_led) begin
                failures++;
                $display("FAIL %s led cyc=%0d got=%b exp=%b", name, k, led, exp_led);
            end
            checks++;
            if (sevenseg !== exp_seg) begin
                failures++;
                $display("FAIL %s sevenseg cyc=%0d got=%h exp=%h", name, k, sevenseg, exp_seg);
            end
            checks++;
            if (rinse2 !== exp_r2) begin
                failures++;
                $display("FAIL %s rinse2 cyc=%0d got=%b exp=%b", name, k, rinse2, exp_r2);
            end
            checks++;
            if (spin2 !== exp_s2) begin
                failures++;
                $display("FAIL %s spin2 cyc=%0d got=%b exp=%b", name, k, spin2, exp_s2);
            end

            if (abort_spin && act && ledb[idx] == 3 && kind[idx] == 0 && elapsed - pstart == 5) begin
                #1 rst_n = 1'b0;
                start_btn = 1'b0; sw6 = 1'b0;
                #1;
                check_idle({name, "_in_reset"});
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
                #1;
                check_idle({name, "_after_reset"});
                break;
            end
            if (!act) begin
                done_cnt++;
                if (done_cnt == 3) break;
            end
            @(posedge clk); #1;
            if (!pz) elapsed++;
            k++;
        end
        start_btn = 1'b0; sw6 = 1'b0;
        $display("run %s size=%b temp=%b r2=%0d s2=%0d pause_at=%0d len=%0d cycles=%0d errs=%0d",
                 name, size, temp, r2, s2, pause_at, pause_len, k, failures - f0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_held");
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check_idle("reset_released");
        end
    endtask

    task automatic test_lid_start_ignored();
        sw6 = 1'b1; start_btn = 1'b1;
        @(posedge clk); #1;
        start_btn = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check_idle("lid_open_start");
        end
        sw6 = 1'b0;
        @(posedge clk); #1;
        check_idle("lid_closed_no_start");
    endtask

    task automatic test_full_options();
        run_cycle(2'b00, 2'b00, 1'b1, 1'b1, 10000, 0, 1, 1'b0, "full_options");
    endtask

    task automatic test_large_hot();
        run_cycle(2'b10, 2'b10, 1'b0, 1'b0, 10000, 0, 1, 1'b0, "large_hot");
    endtask

    task automatic test_pause();
        // Small fill is 20 cycles, so cycle 27 falls inside WASH.
        run_cycle(2'b00, 2'(1 + $urandom_range(0, 1)), 1'($urandom), 1'($urandom), 27, 25, 1, 1'b0, "pause_wash");
    endtask

    task automatic test_held_start();
        run_cycle(2'b01, 2'b01, 1'b0, 1'b0, 10000, 0, 40, 1'b0, "held_start");
    endtask

    task automatic test_reset_mid_spin();
        run_cycle(2'b00, 2'b11, 1'b1, 1'b1, 10000, 0, 1, 1'b1, "reset_spin");
        run_cycle(2'b11, 2'b01, 1'b0, 1'b1, 10000, 0, 1, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            run_cycle(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 150)), int'($urandom_range(1, 30)),
                      int'($urandom_range(1, 20)), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_lid_start_ignored();
        test_full_options();
        test_large_hot();
        test_pause();
        test_held_start();
        test_reset_mid_spin();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
